// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared port identifiers and in-flight tag type for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;

    typedef struct packed {
        logic     vld;
        port_id_t port;
        logic     rd;
    } inflight_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant with last-grant pointer.
//            MEM_ARB_FIXED_PRIO_EN selects fixed priority (port 1 always wins).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    port_id_t r_last;

    // Grant is suppressed during reset so no request looks accepted.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            if (valid[1]) begin
                grant = 2'b10;
            end else if (valid[0]) begin
                grant = 2'b01;
            end
`else
            if (valid == 2'b11) begin
                grant = (r_last == PORT_DATA) ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_DATA;
        end else if (advance) begin
            r_last <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port SRAM between fetch (port 0) and data
//            (port 1) with 1-cycle read latency. Build option:
//            MEM_ARB_FIXED_PRIO_EN (port 1 always wins contention).
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    output logic            req0_ready,
    output logic            rsp0_valid,
    output logic [XLEN-1:0] rsp0_rdata,
    input  logic            req1_valid,
    input  logic            req1_we,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_wdata,
    output logic            req1_ready,
    output logic            rsp1_valid,
    output logic [XLEN-1:0] rsp1_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-3:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_rsp_live;
    logic          w_unused_addr_lsbs;
    inflight_tag_t r_tag;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (w_accept),
        .grant   (w_grant)
    );

    assign w_accept   = |w_grant;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign mem_en    = w_accept;
    assign mem_we    = w_grant[1] & req1_we;
    assign mem_addr  = w_grant[1] ? req1_addr[AW-1:2] : req0_addr[AW-1:2];
    assign mem_wdata = req1_wdata;

    // Byte offset within the word carries no meaning for a word-wide SRAM.
    assign w_unused_addr_lsbs = ^{req0_addr[1:0], req1_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag <= '0;
        end else begin
            r_tag.vld  <= w_accept;
            r_tag.port <= w_grant[1];
            r_tag.rd   <= w_grant[0] | ~req1_we;
        end
    end

    // Gating with rst drops a response whose accept preceded reset.
    assign w_rsp_live = r_tag.vld & ~rst;
    assign rsp0_valid = w_rsp_live & (r_tag.port == PORT_FETCH);
    assign rsp1_valid = w_rsp_live & (r_tag.port == PORT_DATA);
    assign rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    assign rsp1_rdata = (rsp1_valid & r_tag.rd) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with an SRAM model and a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req1_we;
    logic [31:0] req0_addr, req1_addr, req1_wdata;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.XLEN(32), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro: registered read, write on enable.
    logic [31:0] sram [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= sram[mem_addr[3:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] m_mem [16];
    bit          m_last;
    bit          acc0, acc1;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one access per cycle; contention goes to the port not served last.
    task automatic check_and_model();
        bit          e0, e1, we;
        logic [31:0] addr;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            chk("rst_ready", {req1_ready, req0_ready}, 64'd0);
            chk("rst_mem", {mem_en, mem_we}, 64'd0);
            chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 64'd0);
            chk("rst_rsp_rdata", {rsp1_rdata, rsp0_rdata}, 64'd0);
            return;
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        e1 = req1_valid;
        e0 = req0_valid && !req1_valid;
`else
        e0 = req0_valid && !(req1_valid && !m_last);
        e1 = req1_valid && !(req0_valid && m_last);
`endif
        chk("grant", {req1_ready, req0_ready}, {e1, e0});
        chk("mem_en", mem_en, e0 | e1);
        if (e0 | e1) begin
            addr = e1 ? req1_addr : req0_addr;
            we   = e1 & req1_we;
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, addr[31:2]);
            if (we) begin
                chk("mem_wdata", mem_wdata, req1_wdata);
                m_mem[addr[5:2]] = req1_wdata;
                q.push_back('{1'b1, 32'h0, cyc + 1});
            end else begin
                q.push_back('{e1, m_mem[addr[5:2]], cyc + 1});
            end
            m_last = e1;
            acc0   = e0;
            acc1   = e1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic do_reset(input bit on);
        rst = on;
        if (on) begin
            q.delete();
            m_last = 1'b1;
        end
    endtask

    // Monitor: each response must match the oldest expectation, exactly on time.
    always @(negedge clk) begin
        rsp_t e;
        if (rsp0_valid && rsp1_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_both: rsp0_valid=1 rsp1_valid=1 expected at most one (cycle %0d)", cyc);
        end else if (rsp0_valid || rsp1_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: port %0d responded, expected no response (cycle %0d)",
                         rsp1_valid, cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_port", rsp1_valid, e.port);
                chk("rsp_rdata", rsp1_valid ? rsp1_rdata : rsp0_rdata, e.data);
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            v       = $urandom;
            sram[i] = v;
            m_mem[i] = v;
        end
        sram[2]  = 32'h0020_8233;
        m_mem[2] = 32'h0020_8233;
        mem_rdata = 32'h0;

        req0_valid = 1'b1; req0_addr = 32'h0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h4; req1_wdata = 32'h0;
        do_reset(1'b1);
        tick();
        tick();
        do_reset(1'b0);

        // Contention: four cycles of both ports valid.
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_addr = 32'(i * 4);
            req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'(32 + i * 4);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        // Single fetch from word 2.
        req0_valid = 1'b1; req0_addr = 32'h8;
        tick();
        tick();

        // Write then read the same word.
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h10; req1_wdata = 32'hDEAD_BEEF;
        tick();
        req0_valid = 1'b1; req0_addr = 32'h10;
        tick();
        tick();

        // Reset right after a fetch is accepted: its response must vanish.
        req0_valid = 1'b1; req0_addr = 32'h8;
        tick();
        do_reset(1'b1);
        tick();
        do_reset(1'b0);
        tick();

        // Randomised traffic with byte-offset noise on addresses.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1;
                req0_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1;
                req1_we    = 1'($urandom);
                req1_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                req1_wdata = $urandom;
            end
            tick();
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
